// File: rtl/registro_rtc_bank.sv
// registro_rtc_bank: shadow/commit register bank for RTC time fields.
// Writes land in per-register shadow copies, marked dirty. A commit copies
// every dirty shadow register to the outputs in a single edge.
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   LL_signal   write strobe; only its rising edge writes
//   reg_select  1-based target register (0 = none)
//   dato_rtc    write data
//   commit      level-sampled commit request
//   regs_out    committed registers, register k at [k*DATA_W-1:(k-1)*DATA_W]
//   dirty       bit k-1 set = shadow register k written since last commit
//   wr_ack      1-cycle pulse per accepted write
//   sel_err     1-cycle pulse per write with an illegal select
//   bcd_err     1-cycle pulse per write rejected for non-BCD data
//   updated     1-cycle pulse after a commit that loaded regs_out
//
// Optional feature: define REGISTRO_RTC_BCD_CHECK_EN to reject writes whose
// data contains a nibble above 9 (DATA_W must then be a multiple of 4).
// Without it, all data is accepted and bcd_err stays 0.
module registro_rtc_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_REGS = 9,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       LL_signal,
  input  logic [SEL_W-1:0]           reg_select,
  input  logic [DATA_W-1:0]          dato_rtc,
  input  logic                       commit,
  output logic [N_REGS*DATA_W-1:0]   regs_out,
  output logic [N_REGS-1:0]          dirty,
  output logic                       wr_ack,
  output logic                       sel_err,
  output logic                       bcd_err,
  output logic                       updated
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N_REGS);

  logic [N_REGS-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [N_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [N_REGS-1:0]             dirty_q, dirty_d;
  logic                          ll_q;
  logic                          wr_ack_q, wr_ack_d;
  logic                          sel_err_q, sel_err_d;
  logic                          bcd_err_q, bcd_err_d;
  logic                          updated_q, updated_d;

  logic wr_ev;
  logic sel_ok;
  logic data_ok;

  // Write-event qualification: rising edge of the strobe, select range, data legality.
  always_comb begin
    wr_ev  = LL_signal & ~ll_q;
    sel_ok = (reg_select != '0) && (reg_select <= MAX_SEL);
`ifdef REGISTRO_RTC_BCD_CHECK_EN
    data_ok = 1'b1;
    for (int unsigned i = 0; i < DATA_W / 4; i++) begin
      if (dato_rtc[i*4 +: 4] > 4'd9) data_ok = 1'b0;
    end
`else
    data_ok = 1'b1;
`endif
  end

  // Next-state: commit works on pre-edge shadow/dirty, then a same-cycle
  // write re-sets its own dirty bit so it survives the commit.
  always_comb begin
    shadow_d  = shadow_q;
    regs_d    = regs_q;
    dirty_d   = dirty_q;
    wr_ack_d  = 1'b0;
    sel_err_d = 1'b0;
    bcd_err_d = 1'b0;
    updated_d = 1'b0;

    if (commit && (dirty_q != '0)) begin
      for (int unsigned k = 0; k < N_REGS; k++) begin
        if (dirty_q[k]) regs_d[k] = shadow_q[k];
      end
      dirty_d   = '0;
      updated_d = 1'b1;
    end

    if (wr_ev) begin
      if (!sel_ok) begin
        sel_err_d = 1'b1;
      end else if (!data_ok) begin
        bcd_err_d = 1'b1;
      end else begin
        wr_ack_d = 1'b1;
        for (int unsigned k = 0; k < N_REGS; k++) begin
          if (reg_select == SEL_W'(k + 1)) begin
            shadow_d[k] = dato_rtc;
            dirty_d[k]  = 1'b1;
          end
        end
      end
    end
  end

  // State registers; reset also discards uncommitted shadow data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q  <= '0;
      regs_q    <= '0;
      dirty_q   <= '0;
      ll_q      <= 1'b0;
      wr_ack_q  <= 1'b0;
      sel_err_q <= 1'b0;
      bcd_err_q <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      regs_q    <= regs_d;
      dirty_q   <= dirty_d;
      ll_q      <= LL_signal;
      wr_ack_q  <= wr_ack_d;
      sel_err_q <= sel_err_d;
      bcd_err_q <= bcd_err_d;
      updated_q <= updated_d;
    end
  end

  assign regs_out = regs_q;
  assign dirty    = dirty_q;
  assign wr_ack   = wr_ack_q;
  assign sel_err  = sel_err_q;
  assign bcd_err  = bcd_err_q;
  assign updated  = updated_q;

endmodule

// File: tb/tb_registro_rtc_bank.sv
// Self-checking bench for registro_rtc_bank (default parameters).
// Each table row is one clock: inputs driven at the falling edge, outputs
// compared 1 time unit after the following rising edge.
module tb_registro_rtc_bank;

  logic        clk;
  logic        rst_n;
  logic        ll;
  logic [3:0]  sel;
  logic [7:0]  dat;
  logic        cmt;
  logic [71:0] regs_out;
  logic [8:0]  dirty;
  logic        wr_ack, sel_err, bcd_err, updated;

  int n_checks = 0;
  int n_errors = 0;

  registro_rtc_bank dut (
    .clk        (clk),
    .reset      (rst_n),
    .LL_signal  (ll),
    .reg_select (sel),
    .dato_rtc   (dat),
    .commit     (cmt),
    .regs_out   (regs_out),
    .dirty      (dirty),
    .wr_ack     (wr_ack),
    .sel_err    (sel_err),
    .bcd_err    (bcd_err),
    .updated    (updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ll;
    logic [3:0]  sel;
    logic [7:0]  d;
    logic        cm;
    logic [71:0] regs;
    logic [8:0]  dirty;
    logic        ack;
    logic        serr;
    logic        berr;
    logic        upd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic l, input logic [3:0] s,
                     input logic [7:0] d, input logic cm, input logic [71:0] regs,
                     input logic [8:0] dr, input logic ack, input logic serr,
                     input logic berr, input logic upd);
    vec_t v;
    v.rst = rst; v.ll = l; v.sel = s; v.d = d; v.cm = cm; v.regs = regs;
    v.dirty = dr; v.ack = ack; v.serr = serr; v.berr = berr; v.upd = upd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [71:0] act,
                     input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [71:0] r, input logic [8:0] dr,
                         input logic ack, input logic serr, input logic berr,
                         input logic upd);
    chk("regs_out", idx, regs_out, r);
    chk("dirty",    idx, 72'(dirty), 72'(dr));
    chk("wr_ack",   idx, 72'(wr_ack), 72'(ack));
    chk("sel_err",  idx, 72'(sel_err), 72'(serr));
    chk("bcd_err",  idx, 72'(bcd_err), 72'(berr));
    chk("updated",  idx, 72'(updated), 72'(upd));
  endtask

  task automatic do_write(input logic [3:0] s, input logic [7:0] d);
    @(negedge clk); ll = 1'b1; sel = s; dat = d;
    @(negedge clk); ll = 1'b0;
  endtask

  localparam logic [71:0] R_B1 = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] R_B2 = 72'h09_08_07_06_05_04_03_02_55;

  initial begin
    rst_n = 1'b0; ll = 1'b0; sel = '0; dat = '0; cmt = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state and basic write/commit.
    add(0,0,0,8'h00,0, 72'h0, 9'h000, 0,0,0,0);
    add(1,0,0,8'h00,0, 72'h0, 9'h000, 0,0,0,0);
    add(1,1,1,8'h02,0, 72'h0, 9'h001, 1,0,0,0);
    add(1,1,1,8'h02,1, 72'h02, 9'h000, 0,0,0,1);
    add(1,0,0,8'h00,0, 72'h02, 9'h000, 0,0,0,0);
    // Fill all nine registers, one commit.
    for (int k = 1; k <= 9; k++) begin
      add(1,1,4'(k),8'(k),0, 72'h02, 9'((1 << k) - 1), 1,0,0,0);
      add(1,0,4'(k),8'(k),0, 72'h02, 9'((1 << k) - 1), 0,0,0,0);
    end
    add(1,0,0,8'h00,1, R_B1, 9'h000, 0,0,0,1);
    add(1,0,0,8'h00,1, R_B1, 9'h000, 0,0,0,0);   // commit with nothing dirty
    // Strobe held high ten cycles: one write only.
    add(1,1,1,8'h55,0, R_B1, 9'h001, 1,0,0,0);
    for (int k = 0; k < 9; k++) add(1,1,1,8'h55,0, R_B1, 9'h001, 0,0,0,0);
    add(1,0,0,8'h00,1, R_B2, 9'h000, 0,0,0,1);
    add(1,0,0,8'h00,0, R_B2, 9'h000, 0,0,0,0);
    // Illegal selects leave a pending dirty bit alone.
    add(1,1,4,8'h40,0, R_B2, 9'h008, 1,0,0,0);
    add(1,0,0,8'h00,0, R_B2, 9'h008, 0,0,0,0);
    add(1,1,0,8'h11,0, R_B2, 9'h008, 0,1,0,0);
    add(1,0,0,8'h11,0, R_B2, 9'h008, 0,0,0,0);
    add(1,1,10,8'h11,0, R_B2, 9'h008, 0,1,0,0);
    add(1,0,0,8'h11,0, R_B2, 9'h008, 0,0,0,0);
    add(1,1,15,8'h11,0, R_B2, 9'h008, 0,1,0,0);
    add(1,0,0,8'h11,0, R_B2, 9'h008, 0,0,0,0);
    // Write coinciding with commit.
    add(0,0,0,8'h00,0, 72'h0, 9'h000, 0,0,0,0);
    add(1,1,1,8'h44,0, 72'h0, 9'h001, 1,0,0,0);
    add(1,0,1,8'h44,0, 72'h0, 9'h001, 0,0,0,0);
    add(1,1,2,8'h33,1, 72'h44, 9'h002, 1,0,0,1);
    add(1,0,0,8'h00,0, 72'h44, 9'h002, 0,0,0,0);
    add(1,0,0,8'h00,1, 72'h3344, 9'h000, 0,0,0,1);
    add(1,0,0,8'h00,0, 72'h3344, 9'h000, 0,0,0,0);
    // Non-BCD data, then last write wins.
`ifdef REGISTRO_RTC_BCD_CHECK_EN
    add(1,1,3,8'h5A,0, 72'h3344, 9'h000, 0,0,1,0);
    add(1,0,3,8'h5A,0, 72'h3344, 9'h000, 0,0,0,0);
`else
    add(1,1,3,8'h5A,0, 72'h3344, 9'h004, 1,0,0,0);
    add(1,0,3,8'h5A,0, 72'h3344, 9'h004, 0,0,0,0);
`endif
    add(1,1,3,8'h59,0, 72'h3344, 9'h004, 1,0,0,0);
    add(1,0,3,8'h59,0, 72'h3344, 9'h004, 0,0,0,0);
    add(1,0,0,8'h00,1, 72'h593344, 9'h000, 0,0,0,1);
    // Strobe held high across reset release writes once.
    add(0,1,1,8'h07,0, 72'h0, 9'h000, 0,0,0,0);
    add(1,1,1,8'h07,0, 72'h0, 9'h001, 1,0,0,0);
    add(1,1,1,8'h07,0, 72'h0, 9'h001, 0,0,0,0);
    add(1,0,0,8'h00,1, 72'h07, 9'h000, 0,0,0,1);
    add(1,0,0,8'h00,0, 72'h07, 9'h000, 0,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst; ll = tbl[i].ll; sel = tbl[i].sel;
      dat = tbl[i].d; cmt = tbl[i].cm;
      @(posedge clk); #1;
      chk_all(i, tbl[i].regs, tbl[i].dirty, tbl[i].ack, tbl[i].serr,
              tbl[i].berr, tbl[i].upd);
    end

    // Asynchronous reset mid-cycle with every register dirty.
    for (int k = 1; k <= 9; k++) do_write(4'(k), 8'(k * 17));
    @(negedge clk); cmt = 1'b1;
    @(negedge clk); cmt = 1'b0;
    for (int k = 1; k <= 8; k++) do_write(4'(k), 8'h99);
    @(negedge clk); ll = 1'b1; sel = 4'd9; dat = 8'h99;
    @(posedge clk); #1;
    chk_all(1000, 72'h99_88_77_66_55_44_33_22_11, 9'h1FF, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all(1001, 72'h0, 9'h000, 0, 0, 0, 0);
    @(negedge clk); ll = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all(1002, 72'h0, 9'h000, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
